// File: rtl/axil_led_req_arbiter_pkg.sv
// Shared types and constants for the two-client AXI4-Lite LED front end.
package axil_led_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_RESP
  } arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [3:0] LED_REG0_OFF = 4'h0;
  localparam logic [3:0] LED_REG1_OFF = 4'h4;
  localparam logic [3:0] LED_REG2_OFF = 4'h8;
  localparam logic [3:0] LED_REG3_OFF = 4'hC;

endpackage

// File: rtl/axil_led_req_arbiter_if.sv
// AXI4-Lite bus bundle between the request arbiter (master) and the LED slave.
interface axil_led_req_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_led_req_arbiter_rr.sv
// Two-way round-robin grant with a last-grant register updated on accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic       accept,
  output logic [1:0] gnt_c,
  output logic       gnt_idx_c
);

  logic last_grant_q, last_grant_d;

  // Contention goes to the client that was not granted last
  always_comb begin
    gnt_idx_c = 1'b0;
    gnt_c     = '0;
    if (req_valid == 2'b11) begin
      gnt_idx_c = ~last_grant_q;
    end else if (req_valid[1]) begin
      gnt_idx_c = 1'b1;
    end
    if (|req_valid) begin
      gnt_c[gnt_idx_c] = 1'b1;
    end
  end

  // Remember the winner whenever a grant is actually taken
  always_comb begin
    last_grant_d = accept ? gnt_idx_c : last_grant_q;
  end

  // Reset to client 1 so client 0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/axil_led_req_arbiter.sv
// Two-client AXI4-Lite master front end for the LED slave; one single-beat
// transaction outstanding. Optional per-transaction abort: AXIL_ARB_TIMEOUT_EN.
module axil_led_req_arbiter
  import axil_led_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_done,
  output logic [DATA_W-1:0]     req_rdata,
  output logic                  req_err,
  axil_led_req_arbiter_if.master m_axi
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("axil_led_req_arbiter supports DATA_W = 32 only");
  end
  if (TIMEOUT_CYC < 3) begin : g_bad_timeout
    $error("axil_led_req_arbiter needs TIMEOUT_CYC >= 3");
  end

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gidx_q, gidx_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept_c, gnt_idx_c;
  logic [1:0]        gnt_c;
  logic [ADDR_W-1:0] sel_addr_c;

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  rr_arbiter2 u_rr (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .req_valid (req_valid),
    .accept    (accept_c),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c)
  );

  // Grant is taken combinationally in IDLE so the AXI valids follow one cycle later
  assign accept_c   = (state_q == IDLE) && ARESETN && (|req_valid);
  assign req_ready  = accept_c ? gnt_c : 2'b00;
  assign sel_addr_c = gnt_idx_c ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];

  // Next-state and registered output computation
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gidx_d    = gidx_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    done_d    = 2'b00;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          addr_d = sel_addr_c & ~ADDR_W'(3);
          gidx_d = gnt_idx_c;
          if (req_write[gnt_idx_c]) begin
            wdata_d   = gnt_idx_c ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi.bvalid) begin
          bready_d       = 1'b0;
          done_d[gidx_q] = 1'b1;
          err_d          = (m_axi.bresp != AXI_RESP_OKAY);
          rdata_d        = '0;
          state_d        = IDLE;
        end
      end
      RD_ADDR: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi.rvalid) begin
          rready_d       = 1'b0;
          done_d[gidx_q] = 1'b1;
          err_d          = (m_axi.rresp != AXI_RESP_OKAY);
          rdata_d        = m_axi.rdata;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AXIL_ARB_TIMEOUT_EN
    if (state_q == IDLE) begin
      if (accept_c) cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_d        = IDLE;
        awvalid_d      = 1'b0;
        wvalid_d       = 1'b0;
        bready_d       = 1'b0;
        arvalid_d      = 1'b0;
        rready_d       = 1'b0;
        done_d         = 2'b00;
        done_d[gidx_q] = 1'b1;
        err_d          = 1'b1;
        rdata_d        = rdata_q;
      end
    end
`endif
  end

  // State and output registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      gidx_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      gidx_q    <= gidx_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign req_done  = done_q;
  assign req_rdata = rdata_q;
  assign req_err   = err_q;

endmodule

// File: tb/tb_axil_led_req_arbiter.sv
// Self-checking bench: behavioural LED slave plus a done-pulse scoreboard.
module tb_axil_led_req_arbiter;
  import axil_led_arb_pkg::*;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int unsigned TO_CYC = 16;
`else
  localparam int unsigned TO_CYC = 256;
`endif

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic [1:0]          req_valid, req_ready, req_write, req_done;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]   req_rdata;
  logic                req_err;

  axil_led_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_axi ();

  axil_led_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
    .req_rdata(req_rdata), .req_err(req_err), .m_axi(m_axi)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          client;
    logic [31:0] rdata;
    bit          chk_rd;
    bit          err;
    int          gcyc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          grants[$];
  logic [31:0] model [4];
  logic [31:0] mem [4];

  // Slave knobs and observation counters
  int          aw_delay = 0;
  bit          rd_err = 0;
  bit          b_never = 0;
  int          aw_hi = 0, w_hi = 0, b_hs_cnt = 0, overlap = 0;
  logic [3:0]  last_awaddr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;

  // Behavioural LED slave, driven on the falling edge
  initial begin
    int aw_cnt;
    bit aw_seen, w_seen, hs_aw, hs_w, hs_ar, hs_b, hs_r;
    logic [3:0]  hs_awaddr, hs_araddr;
    logic [31:0] hs_wdata;
    logic [3:0]  hs_wstrb;
    aw_cnt = 0; aw_seen = 0; w_seen = 0;
    hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
    hs_awaddr = '0; hs_araddr = '0; hs_wdata = '0; hs_wstrb = '0;
    m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.bresp = 2'b00;
    m_axi.arready = 0; m_axi.rvalid = 0; m_axi.rdata = '0; m_axi.rresp = 2'b00;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        aw_cnt = 0; aw_seen = 0; w_seen = 0;
        hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
        m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0;
        m_axi.arready = 0; m_axi.rvalid = 0;
      end else begin
        if (hs_r) m_axi.rvalid = 0;
        if (hs_b) begin m_axi.bvalid = 0; b_hs_cnt++; end
        if (hs_aw) begin aw_seen = 1; last_awaddr = hs_awaddr; end
        if (hs_w) begin w_seen = 1; last_wdata = hs_wdata; last_wstrb = hs_wstrb; end
        if (hs_ar) begin
          m_axi.rvalid = 1;
          m_axi.rdata  = mem[hs_araddr[3:2]];
          m_axi.rresp  = rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
        if (aw_seen && w_seen) begin
          mem[last_awaddr[3:2]] = last_wdata;
          aw_seen = 0; w_seen = 0;
          if (!b_never) begin m_axi.bvalid = 1; m_axi.bresp = AXI_RESP_OKAY; end
        end
        if (m_axi.awvalid) aw_hi++;
        if (m_axi.wvalid) w_hi++;
        if (m_axi.awvalid) begin
          if (aw_cnt >= aw_delay) m_axi.awready = 1;
          else begin m_axi.awready = 0; aw_cnt++; end
        end else begin
          m_axi.awready = 0; aw_cnt = 0;
        end
        m_axi.wready  = m_axi.wvalid;
        m_axi.arready = m_axi.arvalid;
        hs_aw = m_axi.awvalid && m_axi.awready; hs_awaddr = m_axi.awaddr;
        hs_w  = m_axi.wvalid && m_axi.wready;   hs_wdata = m_axi.wdata; hs_wstrb = m_axi.wstrb;
        hs_ar = m_axi.arvalid && m_axi.arready; hs_araddr = m_axi.araddr;
        hs_b  = m_axi.bvalid && m_axi.bready;
        hs_r  = m_axi.rvalid && m_axi.rready;
        if ((m_axi.awvalid || m_axi.wvalid || m_axi.bready) && (m_axi.arvalid || m_axi.rready))
          overlap++;
      end
    end
  end

  // Scoreboard: every done pulse pops the oldest accepted request
  initial begin
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (cyc > 20000) begin
        $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
        $fatal(1);
      end
      if (req_done != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexp_done", 32'(req_done), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("done_client", 32'(req_done), 32'(1) << e.client);
          chk("done_err", 32'(req_err), 32'(e.err));
          if (e.chk_rd) chk("done_rdata", req_rdata, e.rdata);
          if (e.lat >= 0) chk("done_latency", 32'(cyc - e.gcyc), 32'(e.lat));
        end
      end
    end
  end

  // Issue one request from client c; called and returns on a falling edge
  task automatic do_req(input int c, input bit wr, input logic [3:0] a, input logic [31:0] d,
                        input bit exp_err, input bit chk_rd, input int lat);
    exp_t e;
    int   n;
    req_valid[c] = 1'b1;
    req_write[c] = wr;
    req_addr[c*ADDR_W +: ADDR_W]  = a;
    req_wdata[c*DATA_W +: DATA_W] = d;
    #1;
    n = 0;
    while (!req_ready[c] && n < 300) begin
      @(negedge ACLK); #1; n++;
    end
    if (!req_ready[c]) begin
      chk("grant_wait", 32'(req_ready), 32'(1) << c);
    end else begin
      e.client = c;
      e.rdata  = wr ? 32'h0 : model[a[3:2]];
      if (wr) model[a[3:2]] = d;
      e.chk_rd = chk_rd;
      e.err    = exp_err;
      e.gcyc   = cyc;
      e.lat    = lat;
      sb.push_back(e);
      grants.push_back(c);
    end
    @(negedge ACLK);
    req_valid[c] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge ACLK); n++; end
    chk("drain", 32'(sb.size()), 32'h0);
    repeat (2) @(negedge ACLK);
  endtask

  initial begin
    int n;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 4; i++) begin model[i] = '0; mem[i] = '0; end
    repeat (3) @(negedge ACLK);
    chk("rst_req_done", 32'(req_done), 32'h0);
    chk("rst_req_rdata", req_rdata, 32'h0);
    chk("rst_req_err", 32'(req_err), 32'h0);
    chk("rst_awvalid", 32'(m_axi.awvalid), 32'h0);
    chk("rst_wvalid", 32'(m_axi.wvalid), 32'h0);
    chk("rst_bready", 32'(m_axi.bready), 32'h0);
    chk("rst_arvalid", 32'(m_axi.arvalid), 32'h0);
    chk("rst_rready", 32'(m_axi.rready), 32'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("idle_req_ready", 32'(req_ready), 32'h0);

    // Single write then read-back with a zero-wait slave
    do_req(0, 1'b1, LED_REG1_OFF, 32'h0000_0005, 1'b0, 1'b1, 3);
    wait_drain();
    chk("wr_awaddr", 32'(last_awaddr), 32'h4);
    chk("wr_wdata", last_wdata, 32'h5);
    chk("wr_wstrb", 32'(last_wstrb), 32'hF);
    do_req(1, 1'b0, LED_REG1_OFF, 32'h0, 1'b0, 1'b1, 3);
    wait_drain();

    // Both clients request back to back: grants must alternate
    grants.delete();
    overlap = 0;
    fork
      begin
        do_req(0, 1'b1, LED_REG2_OFF, 32'hAAAA_0001, 1'b0, 1'b1, -1);
        do_req(0, 1'b0, LED_REG3_OFF, 32'h0, 1'b0, 1'b1, -1);
      end
      begin
        do_req(1, 1'b1, LED_REG3_OFF, 32'hBBBB_0002, 1'b0, 1'b1, -1);
        do_req(1, 1'b0, LED_REG2_OFF, 32'h0, 1'b0, 1'b1, -1);
      end
    join
    wait_drain();
    chk("rr_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    chk("single_outstanding", 32'(overlap), 32'h0);

    // Slow awready, immediate wready
    aw_delay = 3; aw_hi = 0; w_hi = 0; b_hs_cnt = 0;
    do_req(0, 1'b1, LED_REG0_OFF, 32'h1234_5678, 1'b0, 1'b1, 6);
    wait_drain();
    chk("slow_aw_awvalid_cycles", 32'(aw_hi), 32'd4);
    chk("slow_aw_wvalid_cycles", 32'(w_hi), 32'd1);
    chk("slow_aw_b_handshakes", 32'(b_hs_cnt), 32'd1);
    aw_delay = 0;

    // SLVERR on a read
    rd_err = 1;
    do_req(1, 1'b0, LED_REG0_OFF, 32'h0, 1'b1, 1'b1, 3);
    wait_drain();
    rd_err = 0;

    // Reset while waiting in WR_RESP: outputs clear, no done pulse
    b_never = 1;
    do_req(0, 1'b1, LED_REG3_OFF, 32'hCAFE_0001, 1'b0, 1'b1, -1);
    n = 0;
    while (!m_axi.bready && n < 50) begin @(negedge ACLK); n++; end
    chk("midrst_bready_seen", 32'(m_axi.bready), 32'h1);
    void'(sb.pop_back());
    ARESETN = 1'b0;
    #1;
    chk("midrst_bready", 32'(m_axi.bready), 32'h0);
    chk("midrst_awvalid", 32'(m_axi.awvalid), 32'h0);
    chk("midrst_rdata", req_rdata, 32'h0);
    chk("midrst_err", 32'(req_err), 32'h0);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    b_never = 0;
    repeat (3) @(negedge ACLK);
    chk("midrst_no_done", 32'(req_done), 32'h0);
    do_req(1, 1'b0, LED_REG3_OFF, 32'h0, 1'b0, 1'b1, 3);
    wait_drain();

`ifdef AXIL_ARB_TIMEOUT_EN
    // Slave never answers the write: abort with error after TO_CYC cycles
    b_never = 1;
    do_req(0, 1'b1, LED_REG2_OFF, 32'hDEAD_0003, 1'b1, 1'b0, TO_CYC);
    wait_drain();
    chk("to_bready_dropped", 32'(m_axi.bready), 32'h0);
    b_never = 0;
    do_req(1, 1'b0, LED_REG2_OFF, 32'h0, 1'b0, 1'b1, 3);
    wait_drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_led_req_arbiter.md
# axil_led_req_arbiter

Two-requester AXI4-Lite master front end for the LED slave peripheral (4 × 32-bit registers at byte offsets 0x0–0xC). Lets two fabric-side clients, for example the keypad FSM and the alarm FSM, share the single AXI4-Lite port of the LED slave. Round-robin grant; one outstanding single-beat transaction at a time. Each client gets a done pulse carrying read data and an error flag.

## Interface
Parameters:
- ADDR_W, 4, AXI byte-address width (LED slave decodes bits [3:2])
- DATA_W, 32, AXI data width (fixed 32; other values unsupported)
- TIMEOUT_CYC, 256, cycles allowed per transaction before abort (used only with AXIL_ARB_TIMEOUT_EN)

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  reset, asynchronous assert, active-low
- req_valid  in  2  per-client request; held until matching req_ready
- req_ready  out  2  one-cycle accept pulse, one-hot
- req_write  in  2  per-client: 1 = write, 0 = read
- req_addr  in  2*ADDR_W  per-client byte address, client i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  per-client write data
- req_done  out  2  one-cycle completion pulse to the granted client
- req_rdata  out  DATA_W  read data, valid while req_done nonzero
- req_err  out  1  error flag, valid while req_done nonzero
- m_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  standard AXI4-Lite master signals, widths per ADDR_W/DATA_W

## Operation
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP.
- IDLE: if any req_valid is high, arbitrate, pulse req_ready[g], and latch write, addr, wdata and g. Go to WR_ADDR or RD_ADDR.
- Arbitration: round-robin on last_grant. With both clients valid, the client ≠ last_grant wins. With one valid, that client wins. last_grant updates on every grant.
- WR_ADDR: awvalid and wvalid assert together. Each drops independently on its own handshake. When both have completed, go to WR_RESP with bready = 1.
- WR_RESP: on bvalid, capture bresp and go to IDLE. Pulse req_done[g], with req_err = (bresp ≠ OKAY).
- RD_ADDR: arvalid = 1 until arready, then go to RD_RESP with rready = 1.
- RD_RESP: on rvalid, capture rdata and rresp and go to IDLE. Pulse req_done[g], with req_rdata = rdata and req_err = (rresp ≠ OKAY).
- Fixed fields: awaddr/araddr = latched addr with bits [1:0] forced to 0; wstrb = 4'hF; awprot/arprot = 3'b000.
- req_rdata holds its last value between reads and is cleared on write completion.

## Timing
- Reset values: all outputs 0, state IDLE, last_grant = 1 (client 0 wins the first contention).
- Reset mid-transaction: immediate return to IDLE; no done pulse is issued.
- Grant in cycle N (req_ready high). AXI valid asserts in N+1.
- Best-case latency: with zero-wait slave ready and a response one cycle after the handshake, req_done occurs at N+3.
- req_done asserts in the cycle after the B/R handshake. The next grant can occur in the same cycle as req_done.
- AXI valids are never dropped before their handshake, except on timeout abort.
- A client must not change its request fields between req_valid and req_ready. After req_ready it may issue a new request immediately.

## Configuration
- AXIL_ARB_TIMEOUT_EN defined:
  - A counter clears on grant and increments in every non-IDLE state.
  - Reaching TIMEOUT_CYC − 1 forces IDLE, drops all valids and readies, and pulses req_done[g] with req_err = 1.
- AXIL_ARB_TIMEOUT_EN undefined: no counter; the block waits indefinitely for slave responses.

## Structure
- Package axil_led_arb_pkg holds:
  - state enum
  - AXI resp constants: OKAY = 2'b00, SLVERR = 2'b10
  - LED register offset constants: 0x0, 0x4, 0x8, 0xC
- Sub-module rr_arbiter2: combinational grant from req_valid and last_grant, plus a last_grant register updated on an accept strobe.

## Test plan
- Client 0 writes 0x00000005 to 0x4 with a zero-wait slave -> req_ready[0] at N, awaddr = 0x4, wdata = 5, wstrb = F, req_done[0] at N+3, req_err = 0.
- Client 1 reads 0x4 after that write -> req_done[1] with req_rdata = 0x00000005, req_err = 0.
- Both clients request continuously after reset -> grants alternate 0, 1, 0, 1; only one AXI transaction outstanding at a time.
- Slave delays awready 3 cycles but wready is immediate -> wvalid drops after 1 cycle, awvalid stays high until accepted, single B handshake, correct done.
- Slave returns SLVERR on a read -> req_err = 1 with req_done. Then ARESETN is pulled low during the next WR_RESP -> all outputs 0, no done pulse.
- With AXIL_ARB_TIMEOUT_EN and TIMEOUT_CYC = 16, slave never raises bvalid -> req_done with req_err = 1 exactly 16 cycles after grant, then the next request is served.
